// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: button-stepped LED display mode controller for the board LED bank.
// Latency: led/mode are registered, one cycle after the internal pattern/mode state; press acts DEBOUNCE_CYC+2 cycles after a key fall.
// Backpressure: none; free-running, consumes a raw key level and drives LEDs every cycle.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   key  - raw push-button, active-low, asynchronous to clk
//   led  - LED drive [LEDS_NR-1:0], registered, lit level set by LED_ACTIVE_LOW
//   mode - current mode, registered (0 OFF, 1 BLINK, 2 CHASE, 3 BREATHE)
// Optional feature macro: LED_BREATHE_EN adds BREATHE mode (PWM duty sweep).
module led_mode_sequencer #(
  parameter int LEDS_NR        = 3,
  parameter int TICK_DIV       = 2700000,
  parameter int DEBOUNCE_CYC   = 270000,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key,
  output logic [LEDS_NR-1:0] led,
  output logic [1:0]         mode
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0]      DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [LEDS_NR-1:0] POL_MASK  = {LEDS_NR{LED_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_BLINK   = 2'd1,
`ifdef LED_BREATHE_EN
    M_CHASE   = 2'd2,
    M_BREATHE = 2'd3
`else
    M_CHASE   = 2'd2
`endif
  } mode_e;

  logic               key_s1_q, key_s2_q;
  logic               deb_q;
  logic [DW-1:0]      deb_cnt_q;
  logic [TW-1:0]      presc_q;
  mode_e              mode_q, mode_d;
  logic [LEDS_NR-1:0] pat_q;
  logic [LEDS_NR-1:0] disp_d;
  logic [LEDS_NR-1:0] led_q;
  logic [1:0]         mode_out_q;
`ifdef LED_BREATHE_EN
  logic [7:0]         duty_q;
  logic               dir_dn_q;
  logic [7:0]         pwm_q;
`endif

  logic deb_accept, press, tick;

  always_comb begin
    // The debounced level flips on the DEBOUNCE_CYC-th consecutive cycle of disagreement;
    // the press pulse fires in that same cycle so the mode moves on the accepting edge.
    deb_accept = (key_s2_q != deb_q) && (deb_cnt_q == DEB_LAST);
    press      = deb_accept && !key_s2_q;
    tick       = (presc_q == TICK_LAST);

    mode_d = M_OFF;
    case (mode_q)
      M_OFF:     mode_d = M_BLINK;
      M_BLINK:   mode_d = M_CHASE;
`ifdef LED_BREATHE_EN
      M_CHASE:   mode_d = M_BREATHE;
`endif
      default:   mode_d = M_OFF;
    endcase

    disp_d = pat_q;
`ifdef LED_BREATHE_EN
    if (mode_q == M_BREATHE) disp_d = {LEDS_NR{pwm_q < duty_q}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      deb_q      <= 1'b1;
      deb_cnt_q  <= '0;
      presc_q    <= '0;
      mode_q     <= M_BLINK;
      pat_q      <= '1;
      led_q      <= '1 ^ POL_MASK;
      mode_out_q <= 2'd1;
`ifdef LED_BREATHE_EN
      duty_q     <= 8'd0;
      dir_dn_q   <= 1'b0;
      pwm_q      <= 8'd0;
`endif
    end else begin
      key_s1_q <= key;
      key_s2_q <= key_s1_q;

      if (key_s2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_accept) begin
        deb_q     <= key_s2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end

      // A press restarts the step period so every mode starts with a full tick interval.
      if (press || tick) presc_q <= '0;
      else               presc_q <= presc_q + 1'b1;

      if (press) begin
        mode_q <= mode_d;
        case (mode_d)
          M_OFF:     pat_q <= '0;
          M_BLINK:   pat_q <= '1;
          M_CHASE:   pat_q <= LEDS_NR'(1);
`ifdef LED_BREATHE_EN
          M_BREATHE: begin
            duty_q   <= 8'd0;
            dir_dn_q <= 1'b0;
          end
`endif
          default:   pat_q <= '0;
        endcase
      end else if (tick) begin
        case (mode_q)
          M_BLINK:   pat_q <= ~pat_q;
          M_CHASE:   pat_q <= (pat_q << 1) | (pat_q >> (LEDS_NR - 1));
`ifdef LED_BREATHE_EN
          M_BREATHE: begin
            // Bounce between 0 and 240 in steps of 16, turning at the end points.
            if (!dir_dn_q) begin
              if (duty_q == 8'd240) begin
                dir_dn_q <= 1'b1;
                duty_q   <= 8'd224;
              end else begin
                duty_q <= duty_q + 8'd16;
              end
            end else begin
              if (duty_q == 8'd0) begin
                dir_dn_q <= 1'b0;
                duty_q   <= 8'd16;
              end else begin
                duty_q <= duty_q - 8'd16;
              end
            end
          end
`endif
          default: ;
        endcase
      end

`ifdef LED_BREATHE_EN
      pwm_q <= pwm_q + 8'd1;
`endif
      led_q      <= disp_d ^ POL_MASK;
      mode_out_q <= mode_q;
    end
  end

  assign led  = led_q;
  assign mode = mode_out_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: randomized key stimulus checked cycle by cycle against a behavioural model.
// Latency: model predicts the registered led/mode values after every rising edge.
// Backpressure: none.
module tb_led_mode_sequencer;

  localparam int N  = 3;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam bit AL = 1'b1;
`ifdef LED_BREATHE_EN
  localparam int NM = 4;
`else
  localparam int NM = 3;
`endif
  localparam int ALL  = (1 << N) - 1;
  localparam int MASK = AL ? ALL : 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         key;
  logic [N-1:0] led;
  logic [1:0]   mode;

  always #5 clk = ~clk;

  led_mode_sequencer #(
    .LEDS_NR(N), .TICK_DIV(TD), .DEBOUNCE_CYC(DB), .LED_ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .led(led), .mode(mode)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: mode as an index, blink as on/off, chase as a lit position,
  // breathe as a duty value with a direction; the key path is a 2-deep delay line.
  int m_mode, m_pos, m_duty, m_phase, m_run, m_pwm;
  bit m_lit, m_up, m_deb;
  bit kh[$];
  int exp_led, exp_mode;

  function automatic int disp();
    case (m_mode)
      0:       return 0;
      1:       return m_lit ? ALL : 0;
      2:       return 1 << m_pos;
      default: return (m_pwm < m_duty) ? ALL : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 1; m_lit = 1'b1; m_pos = 0; m_duty = 0; m_up = 1'b1;
    m_phase = 0; m_run = 0; m_pwm = 0; m_deb = 1'b1;
    kh = {1'b1, 1'b1};
    exp_led  = disp() ^ MASK;
    exp_mode = m_mode;
  endtask

  task automatic model_step(input bit k);
    bit seen, press, tick;
    exp_led  = disp() ^ MASK;
    exp_mode = m_mode;
    seen = kh.pop_front();
    kh.push_back(k);
    press = 1'b0;
    if (seen != m_deb) begin
      m_run++;
      if (m_run == DB) begin
        m_deb = seen;
        m_run = 0;
        press = (seen == 1'b0);
      end
    end else begin
      m_run = 0;
    end
    tick    = (m_phase == TD - 1);
    m_phase = press ? 0 : (m_phase + 1) % TD;
    if (press) begin
      m_mode = (m_mode + 1) % NM;
      m_lit = 1'b1; m_pos = 0; m_duty = 0; m_up = 1'b1;
    end else if (tick) begin
      case (m_mode)
        1: m_lit = !m_lit;
        2: m_pos = (m_pos + 1) % N;
        3: begin
          if (m_up) begin
            if (m_duty == 240) begin m_up = 1'b0; m_duty = 224; end
            else m_duty += 16;
          end else begin
            if (m_duty == 0) begin m_up = 1'b1; m_duty = 16; end
            else m_duty -= 16;
          end
        end
        default: ;
      endcase
    end
    m_pwm = (m_pwm + 1) % 256;
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step(key);
  end

  // One cycle: wait for the falling edge and compare outputs with the model.
  task automatic cycle();
    @(negedge clk);
    chk("led", led, exp_led);
    chk("mode", mode, exp_mode);
  endtask

  task automatic hold(input bit lvl, input int n);
    key = lvl;
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1;
    key = 1'b1;
    model_reset();
    repeat (5) cycle();
    chk("rst_led", led, 3'b000);
    chk("rst_mode", mode, 2'd1);
    rst = 1'b0;

    // First blink inversion reaches led 5 cycles after reset release.
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("first_inv", led, (i == 5) ? 3'b111 : 3'b000);
    end

    // Clean press: mode output moves 1 -> 2 on the 6th cycle after the key fall.
    key = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      chk("press_mode", mode, (i >= 6) ? 2'd2 : 2'd1);
    end
    hold(1'b1, 20);
    chk("release_mode", mode, 2'd2);

    // Short glitches must not register as presses.
    for (int g = 0; g < 5; g++) begin
      hold(1'b0, 2);
      hold(1'b1, 2);
    end
    hold(1'b1, 6);
    chk("glitch_mode", mode, 2'd2);

    // Reset mid-debounce with the key held low, released while still low: one press only.
    hold(1'b0, 2);
    rst = 1'b1;
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      chk("rstkey_mode", mode, (i >= 6) ? 2'd2 : 2'd1);
    end
    hold(1'b0, 6);
    hold(1'b1, 12);
    chk("rstkey_release", mode, 2'd2);

    // Press from CHASE wraps to BREATHE or OFF depending on the build.
    hold(1'b0, 10);
`ifdef LED_BREATHE_EN
    chk("wrap_mode", mode, 2'd3);
`else
    chk("wrap_mode", mode, 2'd0);
    chk("wrap_led", led, 3'b111);
`endif
    hold(1'b1, 10);

    // Randomized segments: long holds, short glitches and occasional resets.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        key = 1'($urandom_range(0, 1));
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat ($urandom_range(1, 4)) cycle();
        rst = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end else begin
        hold(1'($urandom_range(0, 1)), $urandom_range(3, 40));
      end
    end
    // Long sweep to walk BREATHE (when present) through its full duty cycle.
    hold(1'b1, 20);
    hold(1'b0, 10);
    hold(1'b1, 200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Controller for the board LED bank. A debounced push-button press steps the bank through display modes: off, blink, chase and optionally breathe. A prescaled step tick drives the pattern for the current mode. It replaces the free-running counter blinker as the single owner of the `led` outputs in the top level.

Parameters:
LEDS_NR, 3, number of LEDs driven (width of `led`)
TICK_DIV, 2700000, clk cycles per pattern step tick (10 Hz at 27 MHz); minimum 2
DEBOUNCE_CYC, 270000, cycles the synchronized key must hold a new level before it is accepted (10 ms); minimum 1
LED_ACTIVE_LOW, 1, 1 = `led` pins sink current (lit = 0); 0 = lit = 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
key  in  1  raw push-button, asynchronous, active-low (0 = pressed)
led  out  LEDS_NR  LED drive, registered, polarity per LED_ACTIVE_LOW
mode  out  2  current mode, registered (0 OFF, 1 BLINK, 2 CHASE, 3 BREATHE)

Behaviour:
- Reset: key synchronizer flops = 1, debounced level = 1, debounce counter = 0, prescaler = 0, mode = BLINK (1), pattern = all ones, duty = 0, direction = up. `led` = pattern mapped through polarity: all 0 if LED_ACTIVE_LOW, else all 1.
- Synchronizer: 2 flops on `key`. Debounce logic sees `key` 2 cycles late.
- Debounce: counter clears whenever the sync level equals the debounced level. While they differ, the counter increments. When the counter reaches DEBOUNCE_CYC-1 while they still differ, the debounced level takes the sync level and the counter clears.
- Press event: one-cycle internal pulse on a debounced 1->0 transition only. Release generates no event. Latency from a clean `key` fall to the press pulse is DEBOUNCE_CYC+2 cycles.
- A key held low through reset deassertion is treated as a new press after DEBOUNCE_CYC+2 cycles.
- Glitches shorter than DEBOUNCE_CYC cycles cause no event.
- Prescaler: counts 0..TICK_DIV-1. The tick pulse is high for one cycle at TICK_DIV-1, then the count wraps to 0.
- On a press event the prescaler clears to 0. The first tick in the new mode therefore occurs TICK_DIV cycles after the mode change.
- Mode FSM, advanced on press event: OFF->BLINK->CHASE->BREATHE->OFF. BREATHE is present only with the optional feature (see below).
- On entry to each mode the pattern loads:
  - OFF: 0
  - BLINK: all ones
  - CHASE: 1 (bit 0 lit)
  - BREATHE: duty = 0, direction = up
- On tick, per mode:
  - OFF: no change.
  - BLINK: pattern inverts.
  - CHASE: pattern rotates left; bit LEDS_NR-1 wraps to bit 0. Exactly one bit is set at all times.
  - BREATHE: duty changes by 16 in the current direction. At 240 going up the direction flips to down; at 0 going down it flips to up. Duty never leaves 0..240.
- Press and tick in the same cycle: the press wins. The mode advances, the entry value loads and the tick is discarded.
- `led` and `mode` update 1 cycle after the internal pattern or mode register changes. `led` = pattern XOR {LEDS_NR{LED_ACTIVE_LOW}}.
- Reset asserted mid-debounce or mid-pattern: all state returns immediately to reset values, with no partial event.

Optional Feature:
Macro `LED_BREATHE_EN`.
- Defined: BREATHE mode exists. An 8-bit free-running PWM counter runs from reset = 0. In BREATHE every pattern bit = (pwm_cnt < duty). At duty 0 all LEDs are off; at duty 240 they are lit 240/256 of the time.
- Not defined: BREATHE mode, the duty register and the PWM counter are omitted. The FSM goes CHASE->OFF, and `mode` never reads 3.

Test Plan (TICK_DIV=4, DEBOUNCE_CYC=3, LEDS_NR=3, LED_ACTIVE_LOW=1):
- Reset 5 cycles, then release -> mode=1, led=3'b000. First inversion to led=3'b111 appears 5 cycles after release (tick at prescaler 3, plus 1 output register cycle).
- Clean key low for 10 cycles then high -> exactly one press event, mode 1->2 at cycle 6 after the key fall. led=3'b110, then 3'b101, 3'b011, 3'b110 on successive ticks, 4 cycles apart.
- Key pulses low for 2 cycles, repeated 5 times with 2-cycle gaps -> no press event, mode unchanged.
- Press timed so the press event coincides with a tick in BLINK -> mode=2, led=3'b110. The next change comes exactly 4 cycles later.
- With `LED_BREATHE_EN`: from mode 2, press -> mode=3, and duty steps 0,16,...,240,224,...,0 over 30 ticks. With the macro undefined, the same press gives mode=0 and led=3'b111.
- Assert rst while key is held low and mid-debounce, then deassert with key still low -> mode=1 for 5 cycles, then mode=2 (one press only). No event on the later release.
